// File: rtl/graph_pkg.sv
// Shared definitions for the point-set generator: FSM state encoding and the
// xorshift32 constants.
package graph_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SEED,
    GEN_X,
    GEN_Y,
    DONE
  } state_e;

  localparam logic [31:0] XS_DEFAULT_SEED = 32'h2463_534D;

  localparam int unsigned XS_SHL_A = 13;
  localparam int unsigned XS_SHR_B = 17;
  localparam int unsigned XS_SHL_C = 5;

  // One xorshift32 step.
  function automatic logic [31:0] xs_step(input logic [31:0] s);
    logic [31:0] t;
    t = s ^ (s << XS_SHL_A);
    t = t ^ (t >> XS_SHR_B);
    t = t ^ (t << XS_SHL_C);
    return t;
  endfunction

endpackage

// File: rtl/xorshift32_core.sv
// xorshift32 state register with load and advance controls.
// Ports:
//   clk, rst   - clock, synchronous active-high reset (state -> default seed)
//   load       - load state with load_val (priority over advance)
//   load_val   - value to load
//   advance    - replace state with its next step
//   state      - current generator state
//   next       - combinational step of state
module xorshift32_core
  import graph_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [31:0] load_val,
  input  logic        advance,
  output logic [31:0] state,
  output logic [31:0] next
);

  assign next = xs_step(state);

  // Generator state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= XS_DEFAULT_SEED;
    end else if (load) begin
      state <= load_val;
    end else if (advance) begin
      state <= next;
    end
  end

endmodule

// File: rtl/graph_pointset_gen.sv
// Fills a table of N_POINTS random (x,y) points bounded by X_RANGE/Y_RANGE,
// drawn from an xorshift32 generator with rejection of out-of-range values.
// Ports:
//   clk, rst          - clock, synchronous active-high reset
//   start, seed       - begin a new run (any state); seed sampled with start
//   busy, done        - run in progress / table valid
//   count             - points written in the current run
//   rejects           - rejected candidates in the current run (saturating)
//   rd_addr           - read index
//   rd_x, rd_y        - point at rd_addr, one cycle later; 0 when out of range
module graph_pointset_gen
  import graph_pkg::*;
#(
  parameter int unsigned N_POINTS = 64,
  parameter int unsigned COORD_W  = 8,
  parameter int unsigned X_RANGE  = 256,
  parameter int unsigned Y_RANGE  = 256,
  parameter int unsigned IDX_W    = $clog2(N_POINTS)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [31:0]        seed,
  output logic               busy,
  output logic               done,
  output logic [IDX_W:0]     count,
  input  logic [IDX_W-1:0]   rd_addr,
  output logic [COORD_W-1:0] rd_x,
  output logic [COORD_W-1:0] rd_y,
  output logic [15:0]        rejects
);

  state_e               state_q, state_d;
  logic [IDX_W:0]       count_d;
  logic [15:0]          rej_d;
  logic [COORD_W-1:0]   px_q, px_d;
  logic [31:0]          seed_q;

  logic                 lfsr_load;
  logic                 lfsr_adv;
  logic [31:0]          lfsr_load_val;
  logic [31:0]          lfsr_state;
  logic [31:0]          lfsr_next;

  logic                 wr_en;
  logic [IDX_W-1:0]     wr_idx;
  logic [COORD_W-1:0]   cx, cy;

  logic [COORD_W-1:0]   x_mem [N_POINTS];
  logic [COORD_W-1:0]   y_mem [N_POINTS];

  // Only the coordinate slices of the candidate are consumed.
  logic                 unused_bits;
  assign unused_bits = ^{lfsr_state, lfsr_next};

  assign lfsr_load_val = (seed_q == 32'h0) ? XS_DEFAULT_SEED : seed_q;
  assign cx            = lfsr_next[COORD_W-1:0];
  assign cy            = lfsr_next[COORD_W+15:16];
  assign wr_idx        = count[IDX_W-1:0];

  xorshift32_core u_lfsr (
    .clk      (clk),
    .rst      (rst),
    .load     (lfsr_load),
    .load_val (lfsr_load_val),
    .advance  (lfsr_adv),
    .state    (lfsr_state),
    .next     (lfsr_next)
  );

  // Next-state, counters and table write control.
  always_comb begin
    state_d   = state_q;
    count_d   = count;
    rej_d     = rejects;
    px_d      = px_q;
    lfsr_load = 1'b0;
    lfsr_adv  = 1'b0;
    wr_en     = 1'b0;
    if (start) begin
      state_d = SEED;
      count_d = '0;
      rej_d   = '0;
    end else begin
      case (state_q)
        IDLE, DONE: ;
        SEED: begin
          lfsr_load = 1'b1;
          state_d   = GEN_X;
        end
        GEN_X: begin
          lfsr_adv = 1'b1;
          // 32-bit compare keeps a full-range bound (2**COORD_W) representable.
          if (32'(cx) < X_RANGE) begin
            px_d    = cx;
            state_d = GEN_Y;
          end else begin
            rej_d = (rejects == 16'hFFFF) ? rejects : rejects + 16'd1;
          end
        end
        GEN_Y: begin
          lfsr_adv = 1'b1;
          if (32'(cy) < Y_RANGE) begin
            wr_en   = 1'b1;
            count_d = count + (IDX_W+1)'(1);
            state_d = (count_d == (IDX_W+1)'(N_POINTS)) ? DONE : GEN_X;
          end else begin
            rej_d = (rejects == 16'hFFFF) ? rejects : rejects + 16'd1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Control registers; busy/done follow the state being entered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      count   <= '0;
      rejects <= '0;
      px_q    <= '0;
      seed_q  <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      count   <= count_d;
      rejects <= rej_d;
      px_q    <= px_d;
      busy    <= (state_d == SEED) || (state_d == GEN_X) || (state_d == GEN_Y);
      done    <= (state_d == DONE);
      if (start) begin
        seed_q <= seed;
      end
    end
  end

  // Point table write port; no reset so it maps onto RAM.
  always_ff @(posedge clk) begin
    if (wr_en && !rst) begin
      x_mem[wr_idx] <= px_q;
      y_mem[wr_idx] <= cy;
    end
  end

  // Registered read port; same-cycle write to the same index reads old data.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_x <= '0;
      rd_y <= '0;
    end else if (32'(rd_addr) < N_POINTS) begin
      rd_x <= x_mem[rd_addr];
      rd_y <= y_mem[rd_addr];
    end else begin
      rd_x <= '0;
      rd_y <= '0;
    end
  end

endmodule
